// File: rtl/rbm_gibbs_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbm_gibbs_controller_pkg
// Description : Shared encodings for the RBM Gibbs-chain controller: FSM state
//               codes, engine pass directions and a state-class helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rbm_gibbs_controller_pkg;

  // FSM state encodings (explicit 3-bit width)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR_UP = 3'd1;
  localparam logic [2:0] ST_RUN_UP = 3'd2;
  localparam logic [2:0] ST_CLR_DN = 3'd3;
  localparam logic [2:0] ST_RUN_DN = 3'd4;
  localparam logic [2:0] ST_OUT    = 3'd5;

  // Engine pass direction
  localparam logic DIR_UP = 1'b0;  // visible -> hidden
  localparam logic DIR_DN = 1'b1;  // hidden -> visible

  // True for the two states in which the engine is running a pass
  function automatic logic is_run_state(input logic [2:0] s);
    return (s == ST_RUN_UP) || (s == ST_RUN_DN);
  endfunction

  // True for the two single-cycle engine clear states
  function automatic logic is_clr_state(input logic [2:0] s);
    return (s == ST_CLR_UP) || (s == ST_CLR_DN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rbm_pass_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : rbm_pass_watchdog
// Description : Per-pass cycle counter. Reloaded on each entry to a run state,
//               counts run cycles and flags expiry on the WDT_CYCLES-th one.
//               Only instantiated when RBM_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_pass_watchdog #(
  parameter int WDT_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Expiry is asserted during the last permitted run cycle so the FSM leaves then
  assign expired = count && (cnt_reg == CNT_LAST);

  // Counter restarts on load and stops advancing once expired
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (count && !expired) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rbm_gibbs_controller.sv
`default_nettype none
// ============================================================================
// Module      : rbm_gibbs_controller
// Description : Runs contrastive-divergence Gibbs chains v0->h0->...->vK->hK
//               on one shared RBM layer engine. Each pass is a one-cycle clear
//               followed by held valid until done; results are latched and the
//               final vK/hK are handed off over a valid/ready port.
//               Optional macro RBM_WATCHDOG_EN adds a per-pass timeout (err).
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_gibbs_controller
  import rbm_gibbs_controller_pkg::*;
#(
  parameter int BITLENGTH   = 12,
  parameter int VISIBLE_DIM = 15,
  parameter int HIDDEN_DIM  = 5,
  parameter int MAX_DIM     = 15,
  parameter int K_WIDTH     = 8,
  parameter int WDT_CYCLES  = 4096
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [VISIBLE_DIM*BITLENGTH-1:0] in_data,
  input  logic [K_WIDTH-1:0]              cfg_k,
  output logic                            eng_clear,
  output logic                            eng_valid,
  output logic                            eng_dir,
  output logic [MAX_DIM*BITLENGTH-1:0]    eng_data,
  input  logic [MAX_DIM*BITLENGTH-1:0]    eng_result,
  input  logic                            eng_done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [VISIBLE_DIM*BITLENGTH-1:0] out_visible,
  output logic [HIDDEN_DIM*BITLENGTH-1:0] out_hidden,
  output logic                            busy,
  output logic [K_WIDTH-1:0]              step,
  output logic                            err
);

  localparam int VIS_W = VISIBLE_DIM * BITLENGTH;
  localparam int HID_W = HIDDEN_DIM * BITLENGTH;
  localparam int ENG_W = MAX_DIM * BITLENGTH;

  logic [2:0]         state_reg, state_next;
  logic [VIS_W-1:0]   vis_reg;
  logic [HID_W-1:0]   hid_reg;
  logic [K_WIDTH-1:0] k_reg;
  logic [K_WIDTH-1:0] step_reg;
  logic               first_run;
  logic               accept;
  logic               done_ok;
  logic               expired;
  logic [ENG_W-1:0]   vis_pad, hid_pad;
  logic               unused_result;

  // Bits of the engine result above the active dims are never consumed
  assign unused_result = ^eng_result;

  assign accept  = in_valid && in_ready;
  // A done seen on the first run cycle belongs to the previous pass
  assign done_ok = eng_done && is_run_state(state_reg) && !first_run;

`ifdef RBM_WATCHDOG_EN
  logic err_reg;

  rbm_pass_watchdog #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .load    (is_clr_state(state_reg)),
    .count   (is_run_state(state_reg)),
    .expired (expired)
  );

  assign err = err_reg;

  // Abort flag: set on timeout, cleared when a new chain is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= 1'b0;
    end else if (expired && !done_ok) begin
      err_reg <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_CLR_UP;
      ST_CLR_UP: state_next = ST_RUN_UP;
      ST_RUN_UP: begin
        if (done_ok)      state_next = (step_reg == k_reg) ? ST_OUT : ST_CLR_DN;
        else if (expired) state_next = ST_OUT;
      end
      ST_CLR_DN: state_next = ST_RUN_DN;
      ST_RUN_DN: begin
        if (done_ok)      state_next = ST_CLR_UP;
        else if (expired) state_next = ST_OUT;
      end
      ST_OUT:    if (out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Zero-extend the latched vectors to the engine port width
  always_comb begin
    vis_pad = '0;
    hid_pad = '0;
    vis_pad[VIS_W-1:0] = vis_reg;
    hid_pad[HID_W-1:0] = hid_reg;
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    eng_clear = 1'b0;
    eng_valid = 1'b0;
    eng_dir   = DIR_UP;
    eng_data  = '0;
    out_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_CLR_UP: begin
        eng_clear = 1'b1;
        eng_data  = vis_pad;
      end
      ST_RUN_UP: begin
        eng_valid = 1'b1;
        eng_data  = vis_pad;
      end
      ST_CLR_DN: begin
        eng_clear = 1'b1;
        eng_dir   = DIR_DN;
        eng_data  = hid_pad;
      end
      ST_RUN_DN: begin
        eng_valid = 1'b1;
        eng_dir   = DIR_DN;
        eng_data  = hid_pad;
      end
      ST_OUT:  out_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Vector, step and K registers plus the first-run-cycle marker
  always_ff @(posedge clock) begin
    if (reset) begin
      vis_reg   <= '0;
      hid_reg   <= '0;
      k_reg     <= '0;
      step_reg  <= '0;
      first_run <= 1'b0;
    end else begin
      first_run <= is_clr_state(state_reg);
      if (accept) begin
        vis_reg  <= in_data;
        k_reg    <= cfg_k;
        step_reg <= '0;
      end else if (done_ok && (state_reg == ST_RUN_UP)) begin
        hid_reg <= eng_result[HID_W-1:0];
      end else if (done_ok && (state_reg == ST_RUN_DN)) begin
        vis_reg  <= eng_result[VIS_W-1:0];
        step_reg <= step_reg + K_WIDTH'(1);
      end
    end
  end

  assign out_visible = vis_reg;
  assign out_hidden  = hid_reg;
  assign step        = step_reg;

endmodule
`default_nettype wire

// File: tb/tb_rbm_gibbs_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbm_gibbs_controller
// Description : Directed self-checking bench for rbm_gibbs_controller with a
//               small behavioural engine (latency L=5, fixed or inverting).
//               Watchdog scenario runs only when RBM_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbm_gibbs_controller;

  localparam int BL    = 12;
  localparam int VD    = 15;
  localparam int HD    = 5;
  localparam int MD    = 15;
  localparam int KW    = 8;
  localparam int VIS_W = VD * BL;
  localparam int HID_W = HD * BL;
  localparam int ENG_W = MD * BL;
  localparam int LAT   = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [VIS_W-1:0] in_data;
  logic [KW-1:0]    cfg_k;
  logic             eng_clear, eng_valid, eng_dir;
  logic [ENG_W-1:0] eng_data;
  logic [ENG_W-1:0] eng_result;
  logic             eng_done;
  logic             out_valid;
  logic             out_ready;
  logic [VIS_W-1:0] out_visible;
  logic [HID_W-1:0] out_hidden;
  logic             busy;
  logic [KW-1:0]    step;
  logic             err;

  int checks   = 0;
  int failures = 0;

  // engine model controls
  logic model_invert  = 1'b0;
  logic model_stale   = 1'b0;
  logic model_done_en = 1'b1;
  int   eng_cnt       = 0;

  // clear-pulse monitor
  int               clr_count = 0;
  logic             clr_dir  [0:63];
  logic [ENG_W-1:0] clr_data [0:63];
  logic             clr_valid[0:63];

  rbm_gibbs_controller #(
    .BITLENGTH(BL), .VISIBLE_DIM(VD), .HIDDEN_DIM(HD), .MAX_DIM(MD),
    .K_WIDTH(KW), .WDT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cfg_k(cfg_k), .eng_clear(eng_clear),
    .eng_valid(eng_valid), .eng_dir(eng_dir), .eng_data(eng_data),
    .eng_result(eng_result), .eng_done(eng_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_visible(out_visible), .out_hidden(out_hidden),
    .busy(busy), .step(step), .err(err)
  );

  always #5 clock = ~clock;

  // engine: counts valid cycles since the last clear, done on the LAT-th
  always @(posedge clock) begin
    if (eng_clear) eng_cnt <= 0;
    else if (eng_valid) eng_cnt <= eng_cnt + 1;
  end

  always_comb begin
    eng_done = model_done_en && eng_valid &&
               ((eng_cnt == LAT - 1) || (model_stale && eng_cnt == 0));
    eng_result = '0;
    for (int i = 0; i < MD; i++) begin
      if (model_invert) eng_result[i*BL] = ~eng_data[i*BL];
      else              eng_result[i*BL] = 1'b1;
    end
  end

  // record every clear pulse (direction, data and valid alongside it)
  always @(negedge clock) begin
    if (eng_clear === 1'b1 && clr_count < 64) begin
      clr_dir[clr_count]   = eng_dir;
      clr_data[clr_count]  = eng_data;
      clr_valid[clr_count] = eng_valid;
      clr_count = clr_count + 1;
    end
  end

  // element i of the vector carries bit b[i]
  function automatic logic [VIS_W-1:0] pack_v(input logic [VD-1:0] b);
    logic [VIS_W-1:0] r;
    r = '0;
    for (int i = 0; i < VD; i++) r[i*BL] = b[i];
    return r;
  endfunction

  function automatic logic [HID_W-1:0] pack_h(input logic [HD-1:0] b);
    logic [HID_W-1:0] r;
    r = '0;
    for (int i = 0; i < HD; i++) r[i*BL] = b[i];
    return r;
  endfunction

  function automatic logic [ENG_W-1:0] pack_e(input logic [MD-1:0] b);
    logic [ENG_W-1:0] r;
    r = '0;
    for (int i = 0; i < MD; i++) r[i*BL] = b[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_chain(input logic [VIS_W-1:0] d, input logic [KW-1:0] k);
    in_data  = d;
    cfg_k    = k;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid, eng_clear, eng_valid, err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl: {rdy,busy,ov,clr,val,err}=%b required 100000",
               {in_ready, busy, out_valid, eng_clear, eng_valid, err});
    end
    checks++;
    if (step !== '0 || out_visible !== '0 || out_hidden !== '0 || eng_data !== '0) begin
      failures++;
      $display("FAIL reset_data: step=%0d vis=%h hid=%h eng=%h required all 0",
               step, out_visible, out_hidden, eng_data);
    end
  endtask

  // K=0, fixed model returning ones; one up pass
  task automatic test_k0();
    int n, c0;
    model_invert = 1'b0;
    c0 = clr_count;
    start_chain(pack_v(15'h5555), 8'd0);
    wait_out(100, n);
    // accept cycle, clear, 5 run cycles, then OUT as the 8th cycle
    checks++;
    if (out_valid !== 1'b1 || n != 6) begin
      failures++;
      $display("FAIL k0_latency: edges=%0d ov=%b required 6 and 1", n, out_valid);
    end
    checks++;
    if (clr_count - c0 != 1 || clr_dir[c0] !== 1'b0 || clr_valid[c0] !== 1'b0) begin
      failures++;
      $display("FAIL k0_clears: count=%0d dir=%b valid=%b required 1,0,0",
               clr_count - c0, clr_dir[c0], clr_valid[c0]);
    end
    checks++;
    if (out_hidden !== pack_h(5'h1F)) begin
      failures++;
      $display("FAIL k0_hidden: got %h required %h", out_hidden, pack_h(5'h1F));
    end
    checks++;
    if (out_visible !== pack_v(15'h5555) || step !== 8'd0) begin
      failures++;
      $display("FAIL k0_visible: vis=%h step=%0d required %h,0",
               out_visible, step, pack_v(15'h5555));
    end
    drain();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL k0_handoff: busy=%b ov=%b required 0,0", busy, out_valid);
    end
  endtask

  // K=2 with inverting model: checks direction/data of every clear pulse
  task automatic test_k2();
    int n, c0;
    logic [MD-1:0] exp_bits[0:4];
    logic          exp_dir [0:4];
    exp_bits[0] = 15'h5555; exp_dir[0] = 1'b0;
    exp_bits[1] = 15'h000A; exp_dir[1] = 1'b1;
    exp_bits[2] = 15'h7FF5; exp_dir[2] = 1'b0;
    exp_bits[3] = 15'h000A; exp_dir[3] = 1'b1;
    exp_bits[4] = 15'h7FF5; exp_dir[4] = 1'b0;
    model_invert = 1'b1;
    c0 = clr_count;
    start_chain(pack_v(15'h5555), 8'd2);
    wait_out(200, n);
    checks++;
    if (out_valid !== 1'b1 || n != 30) begin
      failures++;
      $display("FAIL k2_latency: edges=%0d ov=%b required 30 and 1", n, out_valid);
    end
    checks++;
    if (clr_count - c0 != 5) begin
      failures++;
      $display("FAIL k2_clear_count: got %0d required 5", clr_count - c0);
    end
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (clr_dir[c0+p] !== exp_dir[p] || clr_data[c0+p] !== pack_e(exp_bits[p])) begin
        failures++;
        $display("FAIL k2_pass%0d: dir=%b data=%h required dir=%b data=%h", p,
                 clr_dir[c0+p], clr_data[c0+p], exp_dir[p], pack_e(exp_bits[p]));
      end
    end
    checks++;
    if (out_visible !== pack_v(15'h7FF5) || out_hidden !== pack_h(5'h0A) || step !== 8'd2) begin
      failures++;
      $display("FAIL k2_result: vis=%h hid=%h step=%0d required %h %h 2",
               out_visible, out_hidden, step, pack_v(15'h7FF5), pack_h(5'h0A));
    end
    drain();
  endtask

  // done held high on the first run cycle must be ignored
  task automatic test_stale_done();
    int n;
    model_invert = 1'b0;
    model_stale  = 1'b1;
    start_chain(pack_v(15'h0F0F), 8'd0);
    wait_out(100, n);
    model_stale = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || n != 6) begin
      failures++;
      $display("FAIL stale_done: edges=%0d ov=%b required 6 and 1", n, out_valid);
    end
    drain();
  endtask

  // output back-pressure and no accept in the handoff cycle
  task automatic test_back_to_back();
    int n, c0;
    int bad;
    model_invert = 1'b1;
    start_chain(pack_v(15'h5555), 8'd1);
    wait_out(200, n);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_reach_out: ov=%b required 1", out_valid);
    end
    in_data  = pack_v(15'h1234);
    cfg_k    = 8'd0;
    in_valid = 1'b1;
    c0 = clr_count;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_visible !== pack_v(15'h7FF5) || out_hidden !== pack_h(5'h0A)) bad++;
    end
    checks++;
    if (bad != 0 || clr_count != c0) begin
      failures++;
      $display("FAIL bp_hold: bad_cycles=%0d new_clears=%0d required 0 and 0",
               bad, clr_count - c0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_handoff: busy=%b rdy=%b required 0,1", busy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || eng_clear !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_accept: busy=%b clr=%b required 1,1", busy, eng_clear);
    end
    wait_out(100, n);
    checks++;
    if (out_valid !== 1'b1 || out_visible !== pack_v(15'h1234) || step !== 8'd0) begin
      failures++;
      $display("FAIL bp_second: ov=%b vis=%h step=%0d required 1 %h 0",
               out_valid, out_visible, step, pack_v(15'h1234));
    end
    drain();
  endtask

  // reset in the middle of a down pass, then a fresh K=1 chain
  task automatic test_reset_mid_chain();
    int n;
    model_invert = 1'b1;
    start_chain(pack_v(15'h5555), 8'd3);
    n = 0;
    while (!(eng_valid === 1'b1 && eng_dir === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!(eng_valid === 1'b1 && eng_dir === 1'b1)) begin
      failures++;
      $display("FAIL rst_reach_dn: valid=%b dir=%b required 1,1", eng_valid, eng_dir);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (eng_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || step !== 8'd0 ||
        out_visible !== '0 || out_hidden !== '0) begin
      failures++;
      $display("FAIL rst_mid: val=%b busy=%b rdy=%b step=%0d vis=%h hid=%h required 0 0 1 0 0 0",
               eng_valid, busy, in_ready, step, out_visible, out_hidden);
    end
    start_chain(pack_v(15'h5555), 8'd1);
    wait_out(200, n);
    checks++;
    if (out_valid !== 1'b1 || n != 18 || out_visible !== pack_v(15'h7FF5) ||
        out_hidden !== pack_h(5'h0A) || step !== 8'd1) begin
      failures++;
      $display("FAIL rst_recover: ov=%b edges=%0d vis=%h hid=%h step=%0d required 1 18 %h %h 1",
               out_valid, n, out_visible, out_hidden, step, pack_v(15'h7FF5), pack_h(5'h0A));
    end
    drain();
  endtask

  // K=255: step must reach 255 without wrapping
  task automatic test_kmax();
    int n;
    model_invert = 1'b1;
    start_chain(pack_v(15'h5555), 8'd255);
    wait_out(4000, n);
    checks++;
    if (out_valid !== 1'b1 || n != 511 * 6 || step !== 8'd255 ||
        out_visible !== pack_v(15'h7FF5) || out_hidden !== pack_h(5'h0A)) begin
      failures++;
      $display("FAIL kmax: ov=%b edges=%0d step=%0d vis=%h hid=%h required 1 3066 255",
               out_valid, n, step, out_visible, out_hidden);
    end
    drain();
  endtask

`ifdef RBM_WATCHDOG_EN
  // engine never finishes: abort after 16 run cycles, err clears on next accept
  task automatic test_watchdog();
    int n;
    model_done_en = 1'b0;
    start_chain(pack_v(15'h5555), 8'd2);
    wait_out(100, n);
    checks++;
    if (out_valid !== 1'b1 || n != 17 || err !== 1'b1 || out_visible !== pack_v(15'h5555)) begin
      failures++;
      $display("FAIL wdt_abort: ov=%b edges=%0d err=%b vis=%h required 1 17 1 %h",
               out_valid, n, err, out_visible, pack_v(15'h5555));
    end
    drain();
    model_done_en = 1'b1;
    start_chain(pack_v(15'h5555), 8'd0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL wdt_clear: err=%b required 0", err);
    end
    wait_out(100, n);
    drain();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_k     = '0;
    out_ready = 1'b0;
    test_reset();
    test_k0();
    test_k2();
    test_stale_done();
    test_back_to_back();
    test_reset_mid_chain();
    test_kmax();
`ifdef RBM_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
